screen_wr_arbiter: RTL and testbench

Shares the single screen-buffer write port (WADDR_SCREEN / DATA_IN_SCREEN / MW_SCREEN_ON) between two requesters:
- the keyboard echo path, which issues one-cycle write pulses and cannot be stalled;
- the CPU store path, which uses a request/acknowledge handshake.

It also contains an optional clear engine that zero-fills the whole screen buffer. The block sits between the keyboard-to-ASCII converter, the CPU memory stage and the screen RAM write port.

---
 rtl/screen_wr_arbiter.sv | 151 +++++++++++++++
 tb/tb_screen_wr_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_wr_arbiter.sv
// Screen RAM write-port arbiter: keyboard write FIFO vs CPU req/ack store path, round-robin.
// Define SCREEN_CLEAR_EN to compile in the zero-fill clear engine (CLEAR state).
module screen_wr_arbiter #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BUF_START  = 16'hC000,
    parameter int          BUF_WORDS  = 1200
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        KB_WE,
    input  logic [15:0] KB_ADDR,
    input  logic [15:0] KB_DATA,
    output logic        KB_OVF,
    input  logic        CPU_REQ,
    input  logic [15:0] CPU_ADDR,
    input  logic [15:0] CPU_DATA,
    output logic        CPU_ACK,
    input  logic        CLR_REQ,
    output logic        CLR_BUSY,
    output logic [15:0] WADDR_SCREEN,
    output logic [15:0] DATA_IN_SCREEN,
    output logic        MW_SCREEN_ON
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0] r_fifo [FIFO_DEPTH];
    logic [PW:0] r_wptr, r_rptr;
    logic        r_last_cpu, r_ovf, r_ack, r_we;
    logic [15:0] r_addr, r_data;

    logic        w_empty, w_full, w_cpu_req, w_gnt_kb, w_gnt_cpu, w_push, w_drop;
    logic        w_arb_en, w_clr_we, w_ovf_clr, w_busy;
    logic [15:0] w_clr_addr;
    logic [31:0] w_head;

`ifdef SCREEN_CLEAR_EN
    localparam int CW = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;

    typedef enum logic {ST_ARB, ST_CLEAR} state_t;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_ARB;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr_we    = 1'b0;
        w_clr_addr  = BUF_START;
        w_arb_en    = 1'b0;
        w_ovf_clr   = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (CLR_REQ) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                    w_clr_we    = 1'b1;
                    w_ovf_clr   = 1'b1;
                end else begin
                    w_arb_en = 1'b1;
                end
            end
            ST_CLEAR: begin
                // r_cnt is the index of the clear write currently on the port
                if (r_cnt == CW'(BUF_WORDS - 1)) begin
                    w_state_nxt = ST_ARB;
                end else begin
                    w_cnt_nxt  = r_cnt + CW'(1);
                    w_clr_we   = 1'b1;
                    w_clr_addr = BUF_START + 16'(w_cnt_nxt);
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    assign w_busy = (r_state == ST_CLEAR);
`else
    logic [32:0] w_unused_cfg;
    assign w_unused_cfg = {CLR_REQ, 32'(BUF_WORDS)};
    assign w_arb_en     = 1'b1;
    assign w_clr_we     = 1'b0;
    assign w_clr_addr   = BUF_START;
    assign w_ovf_clr    = 1'b0;
    assign w_busy       = 1'b0;
`endif

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_head    = r_fifo[r_rptr[PW-1:0]];
    // the acknowledge cycle masks the still-held request
    assign w_cpu_req = CPU_REQ & ~r_ack;
    assign w_gnt_kb  = w_arb_en & ~w_empty & (~w_cpu_req | r_last_cpu);
    assign w_gnt_cpu = w_arb_en & w_cpu_req & ~w_gnt_kb;
    assign w_push    = KB_WE & (~w_full | w_gnt_kb);
    assign w_drop    = KB_WE & w_full & ~w_gnt_kb;

    always_ff @(posedge CLK) begin
        if (w_push) r_fifo[r_wptr[PW-1:0]] <= {KB_ADDR, KB_DATA};
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_last_cpu <= 1'b1;
            r_ovf      <= 1'b0;
            r_ack      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            if (w_push)   r_wptr <= r_wptr + (PW+1)'(1);
            if (w_gnt_kb) r_rptr <= r_rptr + (PW+1)'(1);
            if (w_gnt_kb | w_gnt_cpu) r_last_cpu <= w_gnt_cpu;
            if (w_drop)         r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
            r_ack <= w_gnt_cpu;
            if (w_gnt_cpu) begin
                r_we   <= 1'b1;
                r_addr <= CPU_ADDR;
                r_data <= CPU_DATA;
            end else if (w_gnt_kb) begin
                r_we   <= 1'b1;
                r_addr <= w_head[31:16];
                r_data <= w_head[15:0];
            end else if (w_clr_we) begin
                r_we   <= 1'b1;
                r_addr <= w_clr_addr;
                r_data <= 16'h0000;
            end else begin
                r_we   <= 1'b0;
            end
        end
    end

    assign KB_OVF         = r_ovf;
    assign CPU_ACK        = r_ack;
    assign CLR_BUSY       = w_busy;
    assign WADDR_SCREEN   = r_addr;
    assign DATA_IN_SCREEN = r_data;
    assign MW_SCREEN_ON   = r_we;
endmodule

// File: tb/tb_screen_wr_arbiter.sv
// Bench for screen_wr_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed write sequences.
`timescale 1ns/1ps
module tb_screen_wr_arbiter;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] BSTART = 16'hC000;
    localparam int          WORDS  = 8;
`ifdef SCREEN_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0, KB_WE = 1'b0, CPU_REQ = 1'b0, CLR_REQ = 1'b0;
    logic [15:0] KB_ADDR = '0, KB_DATA = '0, CPU_ADDR = '0, CPU_DATA = '0;
    logic        KB_OVF, CPU_ACK, CLR_BUSY, MW_SCREEN_ON;
    logic [15:0] WADDR_SCREEN, DATA_IN_SCREEN;

    screen_wr_arbiter #(.FIFO_DEPTH(DEPTH), .BUF_START(BSTART), .BUF_WORDS(WORDS)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .KB_WE(KB_WE), .KB_ADDR(KB_ADDR), .KB_DATA(KB_DATA), .KB_OVF(KB_OVF),
        .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_DATA(CPU_DATA), .CPU_ACK(CPU_ACK),
        .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY),
        .WADDR_SCREEN(WADDR_SCREEN), .DATA_IN_SCREEN(DATA_IN_SCREEN), .MW_SCREEN_ON(MW_SCREEN_ON)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    int busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    // Reference model: keyboard queue, who-went-last flag, clear progress
    logic [31:0] kbq[$];
    bit          m_last_cpu = 1'b1, m_ack = 1'b0, m_we = 1'b0, m_ovf = 1'b0, m_busy = 1'b0;
    logic [15:0] m_addr = '0, m_data = '0;
    int          m_idx = 0;

    always @(posedge CLK) begin
        bit gk, gc, start, cpu_eff;
        logic [31:0] head;
        cyc++;
        if (!RST_N) begin
            kbq.delete();
            m_last_cpu = 1'b1; m_ack = 1'b0; m_we = 1'b0; m_ovf = 1'b0; m_busy = 1'b0;
            m_addr = '0; m_data = '0; m_idx = 0;
        end else begin
            gk = 1'b0; gc = 1'b0; start = 1'b0; head = '0;
            cpu_eff = CPU_REQ && !m_ack;
            if (!m_busy) begin
                if (CLR_EN && CLR_REQ) start = 1'b1;
                else if (kbq.size() > 0 && (!cpu_eff || m_last_cpu)) gk = 1'b1;
                else if (cpu_eff) gc = 1'b1;
            end
            if (gk) head = kbq.pop_front();
            if (start) m_ovf = 1'b0;
            if (KB_WE) begin
                if (kbq.size() < DEPTH) kbq.push_back({KB_ADDR, KB_DATA});
                else m_ovf = 1'b1;
            end
            m_ack = gc;
            m_we  = 1'b0;
            if (gc) begin
                m_we = 1'b1; m_addr = CPU_ADDR; m_data = CPU_DATA; m_last_cpu = 1'b1;
            end else if (gk) begin
                m_we = 1'b1; m_addr = head[31:16]; m_data = head[15:0]; m_last_cpu = 1'b0;
            end else if (start) begin
                m_busy = 1'b1; m_idx = 0; m_we = 1'b1; m_addr = BSTART; m_data = '0;
            end else if (m_busy) begin
                if (m_idx == WORDS - 1) m_busy = 1'b0;
                else begin
                    m_idx++;
                    m_we = 1'b1; m_addr = BSTART + 16'(m_idx); m_data = '0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en)
            check("model", {CPU_ACK, KB_OVF, CLR_BUSY, MW_SCREEN_ON, WADDR_SCREEN, DATA_IN_SCREEN},
                  {m_ack, m_ovf, m_busy, m_we, m_addr, m_data});
    end

    typedef struct { logic [15:0] a; logic [15:0] d; int c; } wr_t;
    wr_t wlog[$];

    always @(negedge CLK) begin
        wr_t w;
        if (MW_SCREEN_ON === 1'b1) begin
            w.a = WADDR_SCREEN; w.d = DATA_IN_SCREEN; w.c = cyc;
            wlog.push_back(w);
        end
        if (CLR_BUSY === 1'b1) busy_cnt++;
    end

    task automatic check_log(input string name, input int idx, input logic [31:0] exp);
        if (idx < wlog.size()) check(name, {wlog[idx].a, wlog[idx].d}, exp);
        else check({name, "_missing"}, wlog.size(), idx + 1);
    endtask

    task automatic cpu_send(input logic [15:0] a, input logic [15:0] d);
        CPU_ADDR = a; CPU_DATA = d; CPU_REQ = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (CPU_ACK) return;
        end
        check("cpu_ack_timeout", CPU_ACK, 1);
    endtask

    initial begin
        wr_t kbw[$];
        wr_t cpw[$];

        // Reset with both requesters active
        RST_N = 1'b0; KB_WE = 1'b1; CPU_REQ = 1'b1;
        KB_ADDR = 16'hC0FF; KB_DATA = 16'h5555; CPU_ADDR = 16'hC0EE; CPU_DATA = 16'h6666;
        tick(2);
        chk_en = 1'b1;
        check("reset_outputs", {CPU_ACK, KB_OVF, CLR_BUSY, MW_SCREEN_ON, WADDR_SCREEN, DATA_IN_SCREEN}, '0);
        wlog.delete();
        RST_N = 1'b1; KB_WE = 1'b0; CPU_REQ = 1'b0;
        tick();
        check("post_reset_edge_no_write", MW_SCREEN_ON, 0);
        tick(2);
        check("no_stale_kb_write", wlog.size(), 0);

        // CPU alone
        CPU_ADDR = 16'hC010; CPU_DATA = 16'h4142; CPU_REQ = 1'b1;
        tick();
        check("cpu_write", {CPU_ACK, MW_SCREEN_ON, WADDR_SCREEN, DATA_IN_SCREEN}, {2'b11, 16'hC010, 16'h4142});
        tick();
        check("cpu_no_double", {CPU_ACK, MW_SCREEN_ON}, 0);
        CPU_REQ = 1'b0;
        tick(2);

        // Contention: 3 keyboard pulses against a CPU stream
        wlog.delete();
        fork
            begin
                KB_WE = 1'b1; KB_ADDR = 16'hC000; KB_DATA = 16'h6100; tick();
                KB_ADDR = 16'hC001; KB_DATA = 16'h6200; tick();
                KB_ADDR = 16'hC002; KB_DATA = 16'h6300; tick();
                KB_WE = 1'b0;
            end
            begin
                tick();
                cpu_send(16'hC100, 16'h5A01);
                cpu_send(16'hC101, 16'h5A02);
                CPU_REQ = 1'b0;
            end
        join
        tick(4);
        check("contention_count", wlog.size(), 5);
        check_log("cont0_kb",  0, 32'hC000_6100);
        check_log("cont1_cpu", 1, 32'hC100_5A01);
        check_log("cont2_kb",  2, 32'hC001_6200);
        check_log("cont3_cpu", 3, 32'hC101_5A02);
        check_log("cont4_kb",  4, 32'hC002_6300);

        // Overflow: CPU takes every other slot, keyboard pushes 10 in a row
        check("ovf_clear_before", KB_OVF, 0);
        wlog.delete();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    KB_WE = 1'b1; KB_ADDR = 16'hC200 + 16'(i); KB_DATA = 16'h7000 + 16'(i);
                    tick();
                end
                KB_WE = 1'b0;
            end
            begin
                for (int j = 0; j < 5; j++) cpu_send(16'hC400 + 16'(j), 16'h8000 + 16'(j));
                CPU_REQ = 1'b0;
            end
        join
        tick(12);
        check("ovf_flag", KB_OVF, 1);
        foreach (wlog[i]) begin
            if (wlog[i].a[15:8] == 8'hC2) kbw.push_back(wlog[i]);
            else if (wlog[i].a[15:8] == 8'hC4) cpw.push_back(wlog[i]);
        end
        check("ovf_kb_count", kbw.size(), 9);
        check("ovf_cpu_count", cpw.size(), 5);
        for (int i = 0; i < 9 && i < kbw.size(); i++) begin
            int k;
            k = (i < 8) ? i : 9;
            check("ovf_kb_order", {kbw[i].a, kbw[i].d}, {16'hC200 + 16'(k), 16'h7000 + 16'(k)});
        end

`ifdef SCREEN_CLEAR_EN
        // Clear engine, CPU request raised mid-clear
        wlog.delete();
        busy_cnt = 0;
        CLR_REQ = 1'b1;
        tick();
        CLR_REQ = 1'b0;
        check("clr_first", {CLR_BUSY, MW_SCREEN_ON, WADDR_SCREEN, DATA_IN_SCREEN}, {2'b11, 16'hC000, 16'h0000});
        check("clr_ovf_cleared", KB_OVF, 0);
        tick(2);
        CPU_ADDR = 16'hC300; CPU_DATA = 16'h1111; CPU_REQ = 1'b1;
        for (int k = 0; k < 40 && CPU_ACK !== 1'b1; k++) tick();
        check("clr_cpu_ack_seen", CPU_ACK, 1);
        CPU_REQ = 1'b0;
        tick(2);
        check("clr_busy_cycles", busy_cnt, 8);
        check("clr_write_count", wlog.size(), 9);
        for (int i = 0; i < 8; i++) check_log("clr_word", i, {BSTART + 16'(i), 16'h0000});
        check_log("clr_cpu_after", 8, 32'hC300_1111);
        if (wlog.size() >= 9) check("clr_cpu_gap", wlog[8].c - wlog[7].c, 2);

        // Reset mid-clear
        wlog.delete();
        CLR_REQ = 1'b1;
        tick();
        CLR_REQ = 1'b0;
        tick(2);
        RST_N = 1'b0;
        tick();
        check("midclr_reset", {MW_SCREEN_ON, CLR_BUSY}, 0);
        RST_N = 1'b1;
        tick(10);
        check("midclr_writes", wlog.size(), 3);
        check_log("midclr_last", 2, 32'hC002_0000);
`else
        // Clear engine absent: CLR_REQ has no effect and KB_OVF stays set
        wlog.delete();
        CLR_REQ = 1'b1;
        tick();
        CLR_REQ = 1'b0;
        tick(3);
        check("noclr_busy", CLR_BUSY, 0);
        check("noclr_writes", wlog.size(), 0);
        check("noclr_ovf_sticky", KB_OVF, 1);
`endif

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
